// File: rtl/shared_bus_arbiter_if.sv
// rtl/shared_bus_arbiter_if.sv - request/grant/driver-enable bundle for the shared bus arbiter
interface shared_bus_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8
);
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    // Requester side: level requests and per-driver data
    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] drv_data;

    // Arbiter side: registered grant/enable state and the resolved net value
    logic [N_REQ-1:0]        grant;
    logic [N_REQ-1:0]        oe;
    logic [ID_W-1:0]         owner_id;
    logic                    bus_busy;
    logic [DATA_W-1:0]       bus_data;
    logic                    timeout;

    // The arbiter drives ownership and the resolved net
    modport master (
        input  req,
        input  drv_data,
        output grant,
        output oe,
        output owner_id,
        output bus_busy,
        output bus_data,
        output timeout
    );

    // The requesters drive requests and data, and observe ownership
    modport slave (
        output req,
        output drv_data,
        input  grant,
        input  oe,
        input  owner_id,
        input  bus_busy,
        input  bus_data,
        input  timeout
    );
endinterface

// File: rtl/shared_bus_arbiter.sv
// rtl/shared_bus_arbiter.sv - round-robin owner sequencer for one shared net (optional OWNER_TIMEOUT_EN)
module shared_bus_arbiter #(
    parameter int              N_REQ    = 4,
    parameter int              DATA_W   = 8,
    parameter logic [DATA_W-1:0] PARK_VAL = '0,
    parameter int              MAX_HOLD = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    shared_bus_arbiter_if.master bus
);
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    // Ownership tenure: turnaround, drive, park, then back to arbitration
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_TURN    = 2'd1,
        ST_OWN     = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    state_t            state_q,   state_d;
    logic [N_REQ-1:0]  grant_q,   grant_d;
    logic [N_REQ-1:0]  oe_q,      oe_d;
    logic [ID_W-1:0]   owner_q,   owner_d;
    logic [ID_W-1:0]   last_q,    last_d;
    logic              busy_q,    busy_d;
    logic              timeout_q, timeout_d;

    logic [ID_W-1:0]   rr_win;
    logic              rr_found;
    logic              owner_req;
    logic [DATA_W-1:0] bus_data_c;

`ifdef OWNER_TIMEOUT_EN
    localparam int              CNT_W     = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    logic [CNT_W-1:0] hold_q, hold_d;
`endif

    // Only the current owner's request matters once a tenure has started
    assign owner_req = bus.req[owner_q];

    // Round-robin search starting just after the previous owner, wrapping around
    always_comb begin
        rr_win   = '0;
        rr_found = 1'b0;
        for (int off = 1; off <= N_REQ; off++) begin
            if (!rr_found && bus.req[ID_W'((int'(last_q) + off) % N_REQ)]) begin
                rr_win   = ID_W'((int'(last_q) + off) % N_REQ);
                rr_found = 1'b1;
            end
        end
    end

    // Tenure sequencing and registered output next-state
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        oe_d      = oe_q;
        owner_d   = owner_q;
        last_d    = last_q;
        busy_d    = busy_q;
        timeout_d = 1'b0;
`ifdef OWNER_TIMEOUT_EN
        hold_d    = hold_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (rr_found) begin
                    grant_d = N_REQ'(1) << rr_win;
                    owner_d = rr_win;
                    busy_d  = 1'b1;
                    state_d = ST_TURN;
                end
            end
            ST_TURN: begin
                if (owner_req) begin
                    oe_d    = grant_q;
                    state_d = ST_OWN;
`ifdef OWNER_TIMEOUT_EN
                    hold_d  = '0;
`endif
                end else begin
                    // Abandoned during turnaround still counts as a served turn
                    grant_d = '0;
                    last_d  = owner_q;
                    state_d = ST_RELEASE;
                end
            end
            ST_OWN: begin
                if (!owner_req) begin
                    oe_d    = '0;
                    grant_d = '0;
                    last_d  = owner_q;
                    state_d = ST_RELEASE;
                end
`ifdef OWNER_TIMEOUT_EN
                else if (hold_q == HOLD_LAST) begin
                    // Forced revoke: owner drops to lowest priority like a normal release
                    oe_d      = '0;
                    grant_d   = '0;
                    last_d    = owner_q;
                    timeout_d = 1'b1;
                    state_d   = ST_RELEASE;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
`endif
            end
            ST_RELEASE: begin
                // Park cycle: net is undriven, bus still reported busy
                oe_d    = '0;
                grant_d = '0;
                busy_d  = 1'b0;
                owner_d = '0;
                state_d = ST_IDLE;
            end
            default: begin
                oe_d    = '0;
                grant_d = '0;
                busy_d  = 1'b0;
                owner_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset leaves requester 0 with top priority
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            oe_q      <= '0;
            owner_q   <= '0;
            last_q    <= ID_W'(N_REQ - 1);
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            oe_q      <= oe_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

`ifdef OWNER_TIMEOUT_EN
    // Hold counter for the current OWN tenure
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`endif

    // Resolved net: the enabled driver's data, parked value when nobody drives
    always_comb begin
        bus_data_c = PARK_VAL;
        for (int i = 0; i < N_REQ; i++) begin
            if (oe_q[i]) begin
                bus_data_c = bus.drv_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign bus.grant    = grant_q;
    assign bus.oe       = oe_q;
    assign bus.owner_id = owner_q;
    assign bus.bus_busy = busy_q;
    assign bus.bus_data = bus_data_c;
    assign bus.timeout  = timeout_q;

endmodule
